// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer for the pipelined Y86-64 core: owns F_predPC, selects the
// redirect target and runs the instruction-memory request/ready handshake.
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         M_icode_i,
    input  logic               M_Cnd_i,
    input  logic [63:0]        M_valA_i,
    input  logic [3:0]         W_icode_i,
    input  logic [63:0]        W_valM_i,
    input  logic [63:0]        f_predPC_i,
    input  logic               F_stall_i,
    input  logic               halt_i,
    input  logic               imem_ready_i,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [63:0]        f_pc_o,
    output logic               f_valid_o,
    output logic               fetch_busy_o,
    output logic [63:0]        F_predPC_o
);

    localparam logic [3:0] IJXX = 4'h7;
    localparam logic [3:0] IRET = 4'h9;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [63:0] predpc_q,   predpc_d;
    logic [63:0] pend_q,     pend_d;
    logic        redir_q,    redir_d;

    logic        mis_s;
    logic        ret_s;
    logic        redirect_s;
    logic [63:0] sel_pc_s;
    logic [63:0] fetch_pc_s;
    logic        req_s;
    logic        valid_s;
    logic        busy_s;

    // Redirect selection: a mispredicted jump outranks a returning ret.
    always_comb begin
        mis_s      = (M_icode_i == IJXX) && !M_Cnd_i;
        ret_s      = (W_icode_i == IRET);
        redirect_s = mis_s || ret_s;
        if (mis_s) begin
            sel_pc_s = M_valA_i;
        end else if (ret_s) begin
            sel_pc_s = W_valM_i;
        end else begin
            sel_pc_s = predpc_q;
        end
    end

    // Next-state, handshake outputs and F_predPC update; halt outranks ready and redirect.
    always_comb begin
        state_d    = state_q;
        predpc_d   = predpc_q;
        pend_d     = pend_q;
        redir_d    = redir_q;
        req_s      = 1'b0;
        fetch_pc_s = 64'h0;
        valid_s    = 1'b0;
        busy_s     = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_s      = 1'b1;
                fetch_pc_s = sel_pc_s;
                if (halt_i) begin
                    state_d = ST_HALT;
                end else if (imem_ready_i) begin
                    valid_s = 1'b1;
                    if (!F_stall_i || redirect_s) begin
                        predpc_d = f_predPC_i;
                    end else begin
                        predpc_d = predpc_q;
                    end
                end else begin
                    pend_d  = sel_pc_s;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_s      = 1'b1;
                fetch_pc_s = pend_q;
                busy_s     = 1'b1;
                if (halt_i) begin
                    state_d = ST_HALT;
                end else if (imem_ready_i) begin
                    // A redirect seen during the wait makes the response stale.
                    if (redir_q || redirect_s) begin
                        valid_s = 1'b0;
                        if (redirect_s) begin
                            predpc_d = sel_pc_s;
                        end else begin
                            predpc_d = predpc_q;
                        end
                    end else begin
                        valid_s  = 1'b1;
                        predpc_d = f_predPC_i;
                    end
                    redir_d = 1'b0;
                    state_d = ST_RUN;
                end else if (redirect_s) begin
                    redir_d  = 1'b1;
                    predpc_d = sel_pc_s;
                end else begin
                    redir_d = redir_q;
                end
            end
            ST_HALT: begin
                busy_s = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and F_predPC registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            predpc_q <= RESET_PC;
            pend_q   <= 64'h0;
            redir_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            predpc_q <= predpc_d;
            pend_q   <= pend_d;
            redir_q  <= redir_d;
        end
    end

    assign imem_req_o   = req_s;
    assign imem_addr_o  = IMEM_AW'(fetch_pc_s);
    assign f_pc_o       = fetch_pc_s;
    assign f_valid_o    = valid_s;
    assign fetch_busy_o = busy_s;
    assign F_predPC_o   = predpc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized self-checking bench for pc_fetch_ctrl against a behavioural fetch model.
module tb_pc_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  M_icode_i;
    logic        M_Cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic [63:0] f_predPC_i;
    logic        F_stall_i;
    logic        halt_i;
    logic        imem_ready_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic [63:0] f_pc_o;
    logic        f_valid_o;
    logic        fetch_busy_o;
    logic [63:0] F_predPC_o;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = fetching, 1 = waiting on memory, 2 = halted.
    int          m_mode;
    logic [63:0] m_pred;
    logic [63:0] m_pend;
    bit          m_stale;

    pc_fetch_ctrl #(.RESET_PC(64'h0), .IMEM_AW(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i), .M_valA_i(M_valA_i),
        .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
        .f_predPC_i(f_predPC_i), .F_stall_i(F_stall_i), .halt_i(halt_i),
        .imem_ready_i(imem_ready_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .f_pc_o(f_pc_o), .f_valid_o(f_valid_o),
        .fetch_busy_o(fetch_busy_o), .F_predPC_o(F_predPC_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h time=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_target();
        if (M_icode_i == 4'h7 && !M_Cnd_i) return M_valA_i;
        if (W_icode_i == 4'h9) return W_valM_i;
        return m_pred;
    endfunction

    function automatic bit model_redirect();
        return (M_icode_i == 4'h7 && !M_Cnd_i) || (W_icode_i == 4'h9);
    endfunction

    task automatic set_idle();
        rst_i = 1'b0; M_icode_i = 4'h0; M_Cnd_i = 1'b0; M_valA_i = 64'h0;
        W_icode_i = 4'h0; W_valM_i = 64'h0; f_predPC_i = 64'h0;
        F_stall_i = 1'b0; halt_i = 1'b0; imem_ready_i = 1'b1;
    endtask

    // Inputs are set just after a falling edge; check outputs, then advance the model across the rising edge.
    task automatic step();
        logic [63:0] tgt;
        bit          rd;
        #1;
        tgt = model_target();
        rd  = model_redirect();
        if (!rst_i) begin
            check_eq("req",    {63'h0, imem_req_o},   {63'h0, m_mode != 2});
            check_eq("addr",   imem_addr_o, (m_mode == 0) ? tgt : (m_mode == 1) ? m_pend : 64'h0);
            check_eq("f_pc",   f_pc_o,      (m_mode == 0) ? tgt : (m_mode == 1) ? m_pend : 64'h0);
            check_eq("busy",   {63'h0, fetch_busy_o}, {63'h0, m_mode != 0});
            check_eq("valid",  {63'h0, f_valid_o},
                     {63'h0, !halt_i && imem_ready_i && (m_mode == 0 || (m_mode == 1 && !m_stale && !rd))});
            check_eq("predpc", F_predPC_o, m_pred);
        end
        @(posedge clk_i);
        if (rst_i) begin
            m_mode = 0; m_pred = 64'h0; m_pend = 64'h0; m_stale = 1'b0;
        end else if (m_mode == 2) begin
            m_mode = 2;
        end else if (halt_i) begin
            m_mode = 2;
        end else if (m_mode == 0) begin
            if (imem_ready_i) begin
                if (!F_stall_i || rd) m_pred = f_predPC_i;
            end else begin
                m_pend = tgt;
                m_mode = 1;
            end
        end else begin
            if (imem_ready_i) begin
                if (rd) m_pred = tgt;
                else if (!m_stale) m_pred = f_predPC_i;
                m_stale = 1'b0;
                m_mode  = 0;
            end else if (rd) begin
                m_stale = 1'b1;
                m_pred  = tgt;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        m_mode = 0; m_pred = 64'h0; m_pend = 64'h0; m_stale = 1'b0;
        set_idle();
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        step();
        set_idle();
        #1;
        check_eq("rst_predpc", F_predPC_o, 64'h0);
        check_eq("rst_busy", {63'h0, fetch_busy_o}, 64'h0);

        // Sequential fetch 0, 10, 20 with ready tied high.
        for (int i = 0; i < 3; i++) begin
            f_predPC_i = m_pred + 64'd10;
            #1;
            check_eq("seq_addr", imem_addr_o, 64'(i * 10));
            check_eq("seq_valid", {63'h0, f_valid_o}, 64'h1);
            step();
        end

        // Mispredict and return together: mispredict wins.
        M_icode_i = 4'h7; M_Cnd_i = 1'b0; M_valA_i = 64'h40;
        W_icode_i = 4'h9; W_valM_i = 64'h80; f_predPC_i = 64'h4a;
        #1;
        check_eq("mis_prio", imem_addr_o, 64'h40);
        step();
        set_idle();
        check_eq("mis_next", F_predPC_o, 64'h4a);

        // Return under stall still updates; plain stall holds.
        W_icode_i = 4'h9; W_valM_i = 64'h123; F_stall_i = 1'b1; f_predPC_i = 64'h125;
        #1;
        check_eq("ret_addr", imem_addr_o, 64'h123);
        step();
        W_icode_i = 4'h0; f_predPC_i = 64'h999;
        step();
        check_eq("stall_hold", F_predPC_o, 64'h125);
        F_stall_i = 1'b0;

        // Enter a wait at 0x18, mispredict to 0x50 mid-wait, then a squashed response.
        M_icode_i = 4'h7; M_valA_i = 64'h18; imem_ready_i = 1'b0;
        step();
        M_icode_i = 4'h0;
        step();
        check_eq("wait_addr", imem_addr_o, 64'h18);
        check_eq("wait_busy", {63'h0, fetch_busy_o}, 64'h1);
        M_icode_i = 4'h7; M_valA_i = 64'h50;
        step();
        M_icode_i = 4'h0; imem_ready_i = 1'b1;
        #1;
        check_eq("squash", {63'h0, f_valid_o}, 64'h0);
        step();
        check_eq("after_squash", imem_addr_o, 64'h50);

        // Halt during wait, then reset to recover.
        imem_ready_i = 1'b0;
        step();
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ready_i = i[0];
            step();
            check_eq("halt_noreq", {63'h0, imem_req_o}, 64'h0);
        end
        rst_i = 1'b1;
        step();
        set_idle();
        #1;
        check_eq("resume_addr", imem_addr_o, 64'h0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst_i        = ($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
            M_icode_i    = ($urandom_range(0, 4) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            M_Cnd_i      = 1'($urandom_range(0, 1));
            M_valA_i     = {$urandom, $urandom};
            W_icode_i    = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
            W_valM_i     = {$urandom, $urandom};
            f_predPC_i   = {$urandom, $urandom};
            F_stall_i    = ($urandom_range(0, 4) == 0);
            halt_i       = ($urandom_range(0, 199) == 0);
            imem_ready_i = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
